// File: rtl/vga_overlay_out.sv
// 640x480@60 raster generator with a chroma-keyed overlay composite and a VGA PMOD output byte.
// Colour and syncs leave through one register stage, so they stay aligned.
module vga_overlay_out #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic [5:0]  KEY_COLOR = 6'b100001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       overlay_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  input  logic [5:0] overlay_rgb,
  input  logic [5:0] bg_rgb,
  output logic [5:0] rgb_out,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       frame_start,
  output logic [7:0] uo_pins
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_cnt_q, v_cnt_q;
  logic       ov_q;
  logic       h_end, v_end;
  logic       hs0, vs0;
  logic [5:0] pix;

  assign h_end = (h_cnt_q == H_MAX);
  assign v_end = (v_cnt_q == V_MAX);

  // Overlay enable is only sampled on the frame boundary edge to avoid mid-frame tearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      ov_q    <= 1'b0;
    end else begin
      if (h_end) begin
        h_cnt_q <= '0;
        v_cnt_q <= v_end ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_q <= h_cnt_q + 10'd1;
      end
      if (h_end && v_end) begin
        ov_q <= overlay_en;
      end
    end
  end

  always_comb begin
    active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs0    = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    vs0    = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    pix    = '0;
    if (active) begin
      pix = (ov_q && (overlay_rgb != KEY_COLOR)) ? overlay_rgb : bg_rgb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out     <= '0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      rgb_out     <= pix;
      hsync_n     <= hs0;
      vsync_n     <= vs0;
      frame_start <= (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end
  end

  assign x = h_cnt_q;
  assign y = v_cnt_q;

  // PMOD order: {hsync_n, B0, G0, R0, vsync_n, B1, G1, R1}
  assign uo_pins = {hsync_n, rgb_out[0], rgb_out[2], rgb_out[4],
                    vsync_n, rgb_out[1], rgb_out[3], rgb_out[5]};

endmodule

// File: tb/tb_vga_overlay_out.sv
// Bench for vga_overlay_out: a shrunken-timing instance checked cycle by cycle against a raster
// model, plus a default-timing instance checked over its first few lines.
module tb_vga_overlay_out;

  localparam int unsigned HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int unsigned VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FR = HT * VT;
  localparam logic [5:0] KEY = 6'b100001;

  typedef struct {
    int unsigned h;
    int unsigned v;
    logic [5:0]  ovl;
    logic [5:0]  bg;
    logic [5:0]  exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       overlay_en = 1'b0;
  logic [5:0] ovl = '0, bg = '0;

  logic [9:0] x, y, x2, y2;
  logic       active, active2, hsync_n, hsync_n2, vsync_n, vsync_n2, fs, fs2;
  logic [5:0] rgb, rgb2;
  logic [7:0] uo, uo2;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned t = 0, t2 = 0;
  logic        ov_m = 1'b0;
  int          fs_cnt;
  vec_t        tbl[5];

  vga_overlay_out #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .KEY_COLOR(KEY)
  ) dut (
    .clk(clk), .rst(rst), .overlay_en(overlay_en), .x(x), .y(y), .active(active),
    .overlay_rgb(ovl), .bg_rgb(bg), .rgb_out(rgb), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .frame_start(fs), .uo_pins(uo)
  );

  vga_overlay_out dut_full (
    .clk(clk), .rst(rst), .overlay_en(overlay_en), .x(x2), .y(y2), .active(active2),
    .overlay_rgb(ovl), .bg_rgb(bg), .rgb_out(rgb2), .hsync_n(hsync_n2), .vsync_n(vsync_n2),
    .frame_start(fs2), .uo_pins(uo2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (t=%0d): got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  function automatic logic [5:0] ref_pix(input int unsigned h, input int unsigned v,
                                         input int unsigned hv, input int unsigned vv,
                                         input logic ov, input logic [5:0] o, input logic [5:0] b);
    if (h >= hv || v >= vv) return 6'd0;
    if (ov && o != KEY) return o;
    return b;
  endfunction

  function automatic logic [7:0] ref_pins(input logic hs, input logic vs, input logic [5:0] p);
    logic r1, r0, g1, g0, b1, b0;
    {r1, r0, g1, g0, b1, b0} = p;
    return {hs, b0, g0, r0, vs, b1, g1, r1};
  endfunction

  // One pixel clock: predict from the position shown before the edge, compare after it.
  task automatic step();
    int unsigned h  = t % HT;
    int unsigned v  = (t / HT) % VT;
    int unsigned h2 = t2 % 800;
    int unsigned v2 = (t2 / 800) % 525;
    logic [5:0]  ep, ep2;
    logic        ehs, evs, efs, ehs2, evs2, efs2;
    ep   = ref_pix(h, v, HV, VV, ov_m, ovl, bg);
    ehs  = !(h >= HV + HF && h < HV + HF + HS);
    evs  = !(v >= VV + VF && v < VV + VF + VS);
    efs  = (h == 0 && v == 0);
    ep2  = ref_pix(h2, v2, 640, 480, 1'b0, ovl, bg);
    ehs2 = !(h2 >= 656 && h2 < 752);
    evs2 = !(v2 >= 490 && v2 < 492);
    efs2 = (h2 == 0 && v2 == 0);
    @(posedge clk);
    if (h == HT - 1 && v == VT - 1) ov_m = overlay_en;
    t++;
    t2++;
    @(negedge clk);
    chk("rgb_out", rgb, ep);
    chk("hsync_n", hsync_n, ehs);
    chk("vsync_n", vsync_n, evs);
    chk("frame_start", fs, efs);
    chk("uo_pins", uo, ref_pins(ehs, evs, ep));
    chk("x", x, t % HT);
    chk("y", y, (t / HT) % VT);
    chk("active", active, ((t % HT) < HV) && (((t / HT) % VT) < VV));
    chk("full_rgb_out", rgb2, ep2);
    chk("full_hsync_n", hsync_n2, ehs2);
    chk("full_vsync_n", vsync_n2, evs2);
    chk("full_frame_start", fs2, efs2);
    chk("full_uo_pins", uo2, ref_pins(ehs2, evs2, ep2));
    chk("full_x", x2, t2 % 800);
    chk("full_y", y2, (t2 / 800) % 525);
    if (fs) fs_cnt++;
  endtask

  task automatic rand_step();
    ovl = ($urandom_range(3) == 0) ? KEY : 6'($urandom);
    bg  = 6'($urandom);
    step();
  endtask

  task automatic advance_to(input int unsigned h, input int unsigned v);
    int g = 0;
    while ((t % FR) != v * HT + h && g < 2 * FR) begin
      rand_step();
      g++;
    end
    if (g >= 2 * FR) chk("advance_bound", 32'(g), 32'(2 * FR));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_active"}, active, 1);
    chk({tag, "_rgb_out"}, rgb, 0);
    chk({tag, "_hsync_n"}, hsync_n, 1);
    chk({tag, "_vsync_n"}, vsync_n, 1);
    chk({tag, "_frame_start"}, fs, 0);
    chk({tag, "_uo_pins"}, uo, 8'b10001000);
    chk({tag, "_full_x"}, x2, 0);
    chk({tag, "_full_uo_pins"}, uo2, 8'b10001000);
  endtask

  initial begin
    tbl[0] = '{h: 3,  v: 2,  ovl: 6'b110110, bg: 6'b000011, exp: 6'b110110};
    tbl[1] = '{h: 5,  v: 2,  ovl: 6'b100001, bg: 6'b010101, exp: 6'b010101};
    tbl[2] = '{h: 20, v: 3,  ovl: 6'b110110, bg: 6'b111111, exp: 6'b000000};
    tbl[3] = '{h: 15, v: 11, ovl: 6'b000000, bg: 6'b100000, exp: 6'b000000};
    tbl[4] = '{h: 7,  v: 14, ovl: 6'b101010, bg: 6'b111111, exp: 6'b000000};

    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Frame 0: overlay requested but not yet latched.
    overlay_en = 1'b1;
    ovl = 6'b110110;
    bg  = 6'b000011;
    fs_cnt = 0;
    step();
    chk("first_frame_start", fs, 1);
    chk("frame0_bg", rgb, 6'b000011);
    repeat (FR - 1) step();
    chk("frame_start_count", 32'(fs_cnt), 1);

    // Frame 1: overlay active, table of keyed/blanked cases.
    for (int i = 0; i < 5; i++) begin
      advance_to(tbl[i].h, tbl[i].v);
      ovl = tbl[i].ovl;
      bg  = tbl[i].bg;
      step();
      chk($sformatf("table_%0d", i), rgb, tbl[i].exp);
    end
    advance_to(0, 0);

    // Frame 2: drop the request mid-frame; overlay must persist until the next (0,0).
    advance_to(0, 6);
    overlay_en = 1'b0;
    advance_to(2, 10);
    ovl = 6'b110110;
    bg  = 6'b000011;
    step();
    chk("overlay_persists", rgb, 6'b110110);
    advance_to(0, 0);
    ovl = 6'b110110;
    bg  = 6'b000011;
    step();
    chk("overlay_removed", rgb, 6'b000011);

    // Asynchronous reset in mid-frame.
    overlay_en = 1'b1;
    advance_to(9, 5);
    ovl = KEY;
    bg  = 6'h3f;
    step();
    chk("pre_reset_rgb", rgb, 6'h3f);
    #2 rst = 1'b1;
    #1 check_reset("async_reset");
    @(negedge clk);
    check_reset("held_reset");
    rst  = 1'b0;
    t    = 0;
    t2   = 0;
    ov_m = 1'b0;
    ovl  = 6'b110110;
    bg   = 6'b000011;
    step();
    chk("post_reset_frame_start", fs, 1);
    chk("post_reset_no_overlay", rgb, 6'b000011);
    repeat (FR + 60) rand_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
